// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding, default time constants and tick-counter width
// for the front-panel sequencer.
package timer_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SETTING, RUNNING, PAUSED, EXPIRED} ctrl_state_t;
    localparam int HOLD_MS_DEF   = 500;
    localparam int REPEAT_MS_DEF = 100;
    localparam int BLINK_MS_DEF  = 250;
    localparam int TICK_W        = 10;
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: press detector for one increment button, with optional hold/auto-repeat
// counter (compiled in by TIMER_CTRL_AUTO_REPEAT_EN).
module btn_repeat
    import timer_ctrl_pkg::*;
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
#(
    parameter int HOLD_MS   = HOLD_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic acc,
    input  logic drop,
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
    input  logic en,
    input  logic tick,
    input  logic clr,
`endif
    output logic fire
);
    logic q, q_d, primed, rep;
    // The first sample after reset doubles as the previous one, so a held button is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= 1'b0;
            q_d    <= 1'b0;
            primed <= 1'b0;
        end else begin
            q      <= btn;
            q_d    <= primed ? q : btn;
            primed <= 1'b1;
        end
    end
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
    logic [TICK_W-1:0] cnt, term;
    logic rpt, adv;
    assign term = rpt ? TICK_W'(REPEAT_MS) : TICK_W'(HOLD_MS);
    assign adv  = tick & acc & q;
    assign rep  = adv & (cnt + TICK_W'(1) == term);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rpt <= 1'b0;
        end else if (clr || (en && !q)) begin
            cnt <= '0;
            rpt <= 1'b0;
        end else if (rep) begin
            cnt <= '0;
            rpt <= 1'b1;
        end else if (adv && cnt != term) begin
            cnt <= cnt + TICK_W'(1);
        end
    end
`else
    assign rep = 1'b0;
`endif
    assign fire = acc & ~drop & ((q & ~q_d) | rep);
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: front-panel sequencer turning button levels into timer command pulses.
// Auto-repeat on the increment buttons is compiled in by TIMER_CTRL_AUTO_REPEAT_EN.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int HOLD_MS   = HOLD_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int BLINK_MS  = BLINK_MS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tick_1k,
    input  logic       btn_ss,
    input  logic       btn_rst,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_dir,
    input  logic       time_zero,
    output logic       start,
    output logic       stop,
    output logic       reset,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       inc,
    output logic       alarm,
    output logic [2:0] state_o
);
    if (HOLD_MS < 1 || HOLD_MS > 1023 || REPEAT_MS < 1 || REPEAT_MS > 1023 ||
        BLINK_MS < 1 || BLINK_MS > 1023) begin : g_bad_range
        $error("timer_ctrl: HOLD_MS, REPEAT_MS and BLINK_MS must lie in 1..1023");
    end

    ctrl_state_t state, state_n;
    logic [1:0] b_q, b_d, inc_btn, fire;
    logic primed, tz_q, pr_rst, pr_ss, acc, drop, bhit;
    logic cmd_start, cmd_stop, cmd_reset;
    logic [TICK_W-1:0] bcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            b_d    <= '0;
            primed <= 1'b0;
            tz_q   <= 1'b0;
        end else begin
            b_q    <= {btn_rst, btn_ss};
            b_d    <= primed ? b_q : {btn_rst, btn_ss};
            primed <= 1'b1;
            tz_q   <= time_zero;
        end
    end

    assign pr_rst  = en & b_q[1] & ~b_d[1];
    assign pr_ss   = en & b_q[0] & ~b_d[0];
    assign acc     = en & (state == IDLE || state == SETTING || state == PAUSED);
    assign drop    = pr_rst | pr_ss;
    assign inc_btn = {btn_sec, btn_min};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_repeat
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
            #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS))
`endif
        u_rep (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (inc_btn[i]),
            .acc   (acc),
            .drop  (drop),
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
            .en    (en),
            .tick  (tick_1k),
            .clr   (pr_rst),
`endif
            .fire  (fire[i])
        );
    end

    // Priority: reset button, then start/stop, then expiry, then increments.
    always_comb begin
        state_n   = state;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_reset = 1'b0;
        if (pr_rst) begin
            cmd_reset = 1'b1;
            state_n   = IDLE;
        end else if (pr_ss) begin
            if (state == RUNNING) begin
                cmd_stop = 1'b1;
                state_n  = PAUSED;
            end else if (state == EXPIRED) begin
                cmd_reset = 1'b1;
                state_n   = IDLE;
            end else if (state != IDLE && !tz_q) begin
                cmd_start = 1'b1;
                state_n   = RUNNING;
            end
        end else if (en && state == RUNNING && tz_q) begin
            cmd_stop = 1'b1;
            state_n  = EXPIRED;
        end else if (|fire) begin
            state_n = SETTING;
        end
    end

    assign bhit = tick_1k & (state == EXPIRED) & (bcnt + TICK_W'(1) == TICK_W'(BLINK_MS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start   <= 1'b0;
            stop    <= 1'b0;
            reset   <= 1'b0;
            inc_min <= 1'b0;
            inc_sec <= 1'b0;
            inc     <= 1'b0;
            alarm   <= 1'b0;
            bcnt    <= '0;
        end else begin
            state   <= state_n;
            start   <= cmd_start;
            stop    <= cmd_stop;
            reset   <= cmd_reset;
            inc_min <= fire[0];
            inc_sec <= fire[1];
            inc     <= btn_dir & (state_n != RUNNING);
            if (en) begin
                bcnt  <= (state_n != EXPIRED || state != EXPIRED || bhit) ? '0 : bcnt + TICK_W'(tick_1k);
                alarm <= (state_n == EXPIRED) & ((state != EXPIRED) | (alarm ^ bhit));
            end
        end
    end

    assign state_o = state;
endmodule
